// File: rtl/vga_text_ctrl.sv
// Text-mode 640x480@60 VGA front end: timing, character buffer, cursor and blink.
// Optional scrolling offset is enabled with VGA_TEXT_SCROLL_EN.
module vga_text_ctrl #(
  parameter int unsigned CHAR_W    = 9,
  parameter int unsigned COLS      = 70,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned BLINK_CYC = 12500000
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        cur_we,
  input  logic [6:0]  cur_col,
  input  logic [4:0]  cur_row,
  input  logic        scroll_we,
  input  logic [4:0]  scroll_row,
  output logic        hsync,
  output logic        vsync,
  output logic        c_valid,
  output logic [7:0]  char,
  output logic [3:0]  h_font,
  output logic [3:0]  v_font,
  output logic [6:0]  h_cur,
  output logic [4:0]  v_cur,
  output logic        cursor,
  output logic        clk_1s
);

  localparam logic [3:0]  FX_MAX = 4'(CHAR_W - 1);
  localparam logic [6:0]  COLS_L = 7'(COLS);
  localparam logic [4:0]  ROWS_L = 5'(ROWS);
  localparam int unsigned BW     = $clog2(BLINK_CYC) + 1;
  localparam logic [BW-1:0] BL_MAX = BW'(BLINK_CYC - 1);

  logic [9:0]  h_cnt, v_cnt;
  logic [3:0]  fx, fy;
  logic [6:0]  col;
  logic [4:0]  row;
  logic        h_end, v_end, visible, in_text, cur_hit;
  logic [6:0]  cur_col_q;
  logic [4:0]  cur_row_q;
  logic [4:0]  phys_row;
  logic [11:0] rd_addr;
  logic        wr_ok;
  logic        hs_d1, vs_d1;
  logic [BW-1:0] blink_cnt;

  // Buffer contents are set at configuration time only; reset leaves them alone.
  logic [7:0] mem [4096] = '{default: 8'h20};

  assign h_end = (h_cnt == 10'd799);
  assign v_end = (v_cnt == 10'd524);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      fx    <= '0;
      fy    <= '0;
      col   <= '0;
      row   <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      fx    <= '0;
      col   <= '0;
      if (v_end) begin
        v_cnt <= '0;
        fy    <= '0;
        row   <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
        if (fy == 4'd15) begin
          fy <= '0;
          if (row != ROWS_L) row <= row + 5'd1;
        end else begin
          fy <= fy + 4'd1;
        end
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
      if (fx == FX_MAX) begin
        fx <= '0;
        if (col != COLS_L) col <= col + 7'd1;
      end else begin
        fx <= fx + 4'd1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_col_q <= '0;
      cur_row_q <= '0;
    end else if (cur_we) begin
      cur_col_q <= cur_col;
      cur_row_q <= cur_row;
    end
  end

`ifdef VGA_TEXT_SCROLL_EN
  logic [4:0] offset;
  logic [5:0] row_sum;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      offset <= '0;
    else if (scroll_we && (scroll_row < ROWS_L))
      offset <= scroll_row;
  end

  always_comb begin
    row_sum  = {1'b0, row} + {1'b0, offset};
    phys_row = row_sum[4:0];
    if (row_sum >= {1'b0, ROWS_L})
      phys_row = 5'(row_sum - {1'b0, ROWS_L});
  end
`else
  logic unused_scroll;
  assign unused_scroll = ^{scroll_we, scroll_row};
  assign phys_row      = row;
`endif

  assign visible = (h_cnt < 10'd640) && (v_cnt < 10'd480);
  assign in_text = visible && (col < COLS_L) && (row < ROWS_L);
  assign cur_hit = in_text && (col == cur_col_q) && (row == cur_row_q);
  assign rd_addr = {phys_row, col};
  assign wr_ok   = wr_en && (wr_addr[6:0] < COLS_L) && (wr_addr[11:7] < ROWS_L);

  always_ff @(posedge pclk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Read is non-blocking against the write above, so a colliding write returns old data.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      char    <= '0;
      h_font  <= '0;
      v_font  <= '0;
      h_cur   <= '0;
      v_cur   <= '0;
      cursor  <= 1'b0;
    end else begin
      c_valid <= in_text;
      char    <= mem[rd_addr];
      h_font  <= fx;
      v_font  <= fy;
      h_cur   <= col;
      v_cur   <= row;
      cursor  <= cur_hit;
    end
  end

  // Two-stage sync delay lines up with the colour stage's registered pixel.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d1 <= 1'b1;
      vs_d1 <= 1'b1;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      hs_d1 <= !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
      vs_d1 <= !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
      hsync <= hs_d1;
      vsync <= vs_d1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      clk_1s    <= 1'b0;
    end else if (blink_cnt == BL_MAX) begin
      blink_cnt <= '0;
      clk_1s    <= !clk_1s;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule
